// File: rtl/alu_pkg.sv
// Shared encodings for the R-type issue block: ALU control codes, funct values,
// controller states and exception causes.
package alu_pkg;

    localparam logic [2:0] F_AND = 3'd0;
    localparam logic [2:0] F_OR  = 3'd1;
    localparam logic [2:0] F_ADD = 3'd2;
    localparam logic [2:0] F_SUB = 3'd6;
    localparam logic [2:0] F_SLT = 3'd7;

    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_OVF  = 2'b01,
        CAUSE_ILL  = 2'b10
    } cause_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] f;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] funct);
        dec_t d;
        d.legal = 1'b1;
        d.f     = F_AND;
        case (funct)
            FUNCT_AND: d.f = F_AND;
            FUNCT_OR:  d.f = F_OR;
            FUNCT_ADD: d.f = F_ADD;
            FUNCT_SUB: d.f = F_SUB;
            FUNCT_SLT: d.f = F_SLT;
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// register 0 reads as zero and ignores writes.
module alu_regfile
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  i_ra,
    input  logic [4:0]  i_rb,
    output logic [31:0] o_rda,
    output logic [31:0] o_rdb,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);

    logic [31:0] r_mem [32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rda = (i_ra == 5'd0) ? 32'd0 : r_mem[i_ra];
    assign o_rdb = (i_rb == 5'd0) ? 32'd0 : r_mem[i_rb];

endmodule

// File: rtl/alu_issue.sv
// Two-stage R-type issue/retire controller around an external ALU, with
// result bypass from the issue stage and halt-on-exception handling.
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_funct,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    output logic [2:0]  alu_f,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_y,
    input  logic        alu_zero,
    input  logic        alu_of,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_zero,
    output logic        exc,
    output logic [1:0]  exc_cause,
    input  logic        exc_clr
);

    state_t      r_state, w_state_nxt;
    cause_t      r_cause, w_cause_nxt;

    logic        r_is_valid;
    logic [2:0]  r_is_f;
    logic [31:0] r_is_a, r_is_b;
    logic [4:0]  r_is_rd;

    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_wb_zero;

    dec_t        w_dec;
    logic        w_accept, w_ovf, w_ill, w_we, w_is_load;
    logic [31:0] w_rf_a, w_rf_b, w_op_a, w_op_b;

    assign in_ready  = (r_state == ST_RUN);
    assign w_accept  = in_valid && in_ready;
    assign w_dec     = decode(in_funct);
    assign w_ovf     = r_is_valid && alu_of && ((r_is_f == F_ADD) || (r_is_f == F_SUB));
    assign w_ill     = w_accept && !w_dec.legal;
    assign w_we      = r_is_valid && !w_ovf;
    // An accept coinciding with an overflow is squashed rather than executed.
    assign w_is_load = w_accept && w_dec.legal && !w_ovf;

    alu_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ra  (in_rs),
        .i_rb  (in_rt),
        .o_rda (w_rf_a),
        .o_rdb (w_rf_b),
        .i_we  (w_we),
        .i_wa  (r_is_rd),
        .i_wd  (alu_y)
    );

    assign w_op_a = (r_is_valid && (r_is_rd != 5'd0) && (r_is_rd == in_rs)) ? alu_y : w_rf_a;
    assign w_op_b = (r_is_valid && (r_is_rd != 5'd0) && (r_is_rd == in_rt)) ? alu_y : w_rf_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        case (r_state)
            ST_RUN: begin
                // Overflow outranks a coincident illegal accept.
                if (w_ovf) begin
                    w_state_nxt = ST_HALT;
                    w_cause_nxt = CAUSE_OVF;
                end else if (w_ill) begin
                    w_state_nxt = ST_HALT;
                    w_cause_nxt = CAUSE_ILL;
                end
            end
            ST_HALT: begin
                if (exc_clr) begin
                    w_state_nxt = ST_RUN;
                    w_cause_nxt = CAUSE_NONE;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cause_nxt = CAUSE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_valid <= 1'b0;
            r_is_f     <= '0;
            r_is_a     <= '0;
            r_is_b     <= '0;
            r_is_rd    <= '0;
        end else begin
            r_is_valid <= w_is_load;
            if (w_is_load) begin
                r_is_f  <= w_dec.f;
                r_is_a  <= w_op_a;
                r_is_b  <= w_op_b;
                r_is_rd <= in_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_zero  <= 1'b0;
        end else begin
            r_wb_valid <= w_we;
            if (w_we) begin
                r_wb_rd   <= r_is_rd;
                r_wb_data <= alu_y;
                r_wb_zero <= alu_zero;
            end
        end
    end

    assign alu_f     = r_is_f;
    assign alu_a     = r_is_a;
    assign alu_b     = r_is_b;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign wb_zero   = r_wb_zero;
    assign exc       = (r_state == ST_HALT);
    assign exc_cause = r_cause;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the ports SHALL be listed in this order.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  an R-type instruction is offered.
REQ-005 in_ready  output  1  the block accepts the instruction; a transfer occurs when in_valid && in_ready.
REQ-006 in_funct  input  6  MIPS funct field.
REQ-007 in_rs, in_rt, in_rd  input  5 each  source and destination register indices.
REQ-008 alu_f  output  3  ALU control code.
REQ-009 alu_a, alu_b  output  32 each  ALU operands.
REQ-010 alu_y  input  32  ALU result, combinational from alu_f/alu_a/alu_b.
REQ-011 alu_zero, alu_of  input  1 each  ALU zero and overflow flags.
REQ-012 wb_valid  output  1  single-cycle pulse per retired instruction.
REQ-013 wb_rd  output  5  destination register of the retired instruction.
REQ-014 wb_data  output  32  result of the retired instruction.
REQ-015 wb_zero  output  1  zero flag of the retired instruction.
REQ-016 exc  output  1  block is halted on an exception.
REQ-017 exc_cause  output  2  exception cause: 01 = overflow, 10 = illegal funct, 00 = none.
REQ-018 exc_clr  input  1  acknowledge and clear the exception.

Function
REQ-019 The block SHALL be two stages: stage IS (issue register holding valid, f, a, b, rd) and stage WB (retire register), with the ALU between them.
REQ-020 The decode SHALL map funct to f as follows: 0x24→0 (and), 0x25→1 (or), 0x20→2 (add), 0x22→6 (sub), 0x2A→7 (slt); every other funct is illegal.
REQ-021 in_ready SHALL be 1 in state RUN and 0 in state HALT.
REQ-022 On transfer, operands SHALL be read from the register file at in_rs/in_rt, and IS SHALL load them on that edge; alu_f/alu_a/alu_b SHALL be driven from IS.
REQ-023 Bypass: if IS is valid with rd ≠ 0 and rd equals in_rs (or in_rt), the corresponding operand SHALL be alu_y instead of the register-file value.
REQ-024 Register 0 SHALL always read 0; writes to rd = 0 SHALL be discarded, but wb_valid SHALL still pulse.
REQ-025 When IS is valid and no exception occurs, the edge SHALL write alu_y to regfile[rd] and load WB; wb_valid SHALL be high the following cycle. Latency is 2 cycles from accept to wb_valid.
REQ-026 Overflow SHALL be alu_of qualified by f ∈ {2, 6}; alu_of SHALL be ignored for all other codes.
REQ-027 An illegal funct SHALL be detected at accept; the block SHALL NOT load IS, and SHALL enter HALT with cause 10 on that edge.
REQ-028 On an overflow in IS, there SHALL be no regfile write and no wb_valid pulse; the block SHALL enter HALT with cause 01.
REQ-029 Simultaneous events: an instruction accepted on the same edge an overflow is detected SHALL be squashed (IS cleared, never executed).
REQ-030 Simultaneous events: if overflow and an illegal accept coincide, cause SHALL be 01.
REQ-031 FSM states are RUN and HALT.
REQ-032 RUN→HALT SHALL occur on an exception.
REQ-033 HALT→RUN SHALL occur on exc_clr, at the next edge; exc_cause SHALL clear to 00 on that edge.
REQ-034 exc_clr SHALL be ignored in RUN.
REQ-035 exc SHALL equal (state == HALT).
REQ-036 Back-to-back accepts SHALL sustain one instruction per cycle in RUN, with no stalls.

Reset
REQ-037 With rst_n low at an edge, state SHALL become RUN.
REQ-038 With rst_n low at an edge, IS and WB valid SHALL clear, and all 32 registers SHALL reset to 0.
REQ-039 With rst_n low at an edge, outputs SHALL be: wb_valid = 0, wb_rd = 0, wb_data = 0, wb_zero = 0, exc = 0, exc_cause = 00, alu_f = 0, alu_a = 0, alu_b = 0.
REQ-040 In-flight instructions SHALL be discarded by reset mid-operation; reset SHALL take priority over exc_clr and over accepts.

Structure
REQ-041 Package alu_pkg SHALL hold: the f encodings, the funct constants, the state enum {RUN, HALT}, and the cause codes.
REQ-042 Sub-module alu_regfile SHALL provide a 32x32 register file with 2 read ports, 1 write port, synchronous write and reset, and register 0 hardwired to 0.

Verification
REQ-043 Scenario: reset, then accept add r3,r1,r2 with r1=5, r2=7 → wb_valid 2 cycles later, wb_rd=3, wb_data=12, wb_zero=0.
REQ-044 Scenario: back-to-back add r3,r1,r2 then sub r4,r3,r1 (r1=5, r2=7) → bypass taken, wb_data 12 then 7, consecutive wb_valid pulses.
REQ-045 Scenario: add with r1=0x7FFFFFFF, r2=1 → no writeback, exc=1, exc_cause=01, in_ready=0; a sub offered on the same cycle is squashed.
REQ-046 Scenario: funct 0x03 offered → exc_cause=10; assert exc_clr → RUN the next cycle, exc_cause=00.
REQ-047 Scenario: slt r5,r1,r2 with r1=0x80000000, r2=1 and alu_of high → no exception, wb_data=1; or r0,r1,r2 → wb_valid pulses, r0 still reads 0.
REQ-048 Scenario: rst_n low while IS is valid → no wb_valid, all registers read 0 afterwards.
